// File: rtl/bsg_manycore_hor_io_proc_arbiter_pkg.sv
// Shared definitions for the horizontal IO proc-port arbiter: reg_id width and
// the flat bit layouts of the manycore forward and return packets.
//   forward packet : {addr, op(2), reg_id, payload(data), src_y, src_x, y, x}
//   return packet  : {type(2), data, reg_id, y, x}
package bsg_manycore_hor_io_proc_arbiter_pkg;

  localparam int reg_id_width_gp = 5;

  typedef logic [reg_id_width_gp-1:0] reg_id_t;

  typedef enum logic [1:0] {
    e_return_credit   = 2'd0,
    e_return_int_wb   = 2'd1,
    e_return_float_wb = 2'd2,
    e_return_ifetch   = 2'd3
  } return_packet_type_e;

  function automatic int packet_width(int addr_w, int data_w, int x_w, int y_w);
    return addr_w + 2 + reg_id_width_gp + data_w + 2*y_w + 2*x_w;
  endfunction

  function automatic int packet_reg_id_lsb(int data_w, int x_w, int y_w);
    return data_w + 2*y_w + 2*x_w;
  endfunction

  function automatic int return_packet_width(int data_w, int x_w, int y_w);
    return 2 + data_w + reg_id_width_gp + y_w + x_w;
  endfunction

  function automatic int return_packet_reg_id_lsb(int x_w, int y_w);
    return y_w + x_w;
  endfunction

endpackage

// File: rtl/bsg_manycore_hor_io_proc_arbiter_tag_pool.sv
// Tag pool: free bitvector with lowest-index-free allocation and a count of
// allocated tags. A tag freed this cycle only becomes allocatable next cycle.
module bsg_manycore_hor_io_proc_arbiter_tag_pool #(
  parameter int num_tags_p    = 16,
  parameter int tag_width_p   = 4,
  parameter int count_width_p = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     alloc_v_i,
  input  logic                     free_v_i,
  input  logic [tag_width_p-1:0]   free_tag_i,
  output logic                     avail_o,
  output logic [tag_width_p-1:0]   alloc_tag_o,
  output logic [num_tags_p-1:0]    allocated_o,
  output logic [count_width_p-1:0] count_o
);

  typedef logic [tag_width_p-1:0]   tag_t;
  typedef logic [count_width_p-1:0] count_t;

  logic [num_tags_p-1:0] r_free;
  logic [num_tags_p-1:0] w_free_next;
  count_t                r_count;

  // lowest-index free tag
  always_comb begin
    alloc_tag_o = '0;
    for (int t = num_tags_p - 1; t >= 0; t--) begin
      if (r_free[t]) alloc_tag_o = tag_t'(t);
    end
  end

  // apply free and alloc together; they never target the same tag
  always_comb begin
    w_free_next = r_free;
    if (free_v_i)  w_free_next[free_tag_i]  = 1'b1;
    if (alloc_v_i) w_free_next[alloc_tag_o] = 1'b0;
  end

  // free vector and allocated count
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_free  <= '1;
      r_count <= '0;
    end else begin
      r_free <= w_free_next;
      if (alloc_v_i && !free_v_i)      r_count <= r_count + count_t'(1);
      else if (!alloc_v_i && free_v_i) r_count <= r_count - count_t'(1);
    end
  end

  assign avail_o     = |r_free;
  assign allocated_o = ~r_free;
  assign count_o     = r_count;

endmodule

// File: rtl/bsg_manycore_hor_io_proc_arbiter.sv
// Shares one router P-port among num_req_p accelerators. Requests are
// round-robin arbitrated into a one-deep forward register with reg_id swapped
// for a pool tag; responses are steered back combinationally by tag lookup
// with the original reg_id restored.
// Geometry defaults exist only so the module elaborates standalone; the
// instantiator is expected to set them to the real packet geometry.
module bsg_manycore_hor_io_proc_arbiter
  import bsg_manycore_hor_io_proc_arbiter_pkg::*;
#(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int num_req_p      = 2,
  parameter int num_tags_p     = 16,
  localparam int pkt_w_lp   = packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
  localparam int ret_w_lp   = return_packet_width(data_width_p, x_cord_width_p, y_cord_width_p),
  localparam int count_w_lp = $clog2(num_tags_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [num_req_p-1:0]          req_v_i,
  input  logic [num_req_p*pkt_w_lp-1:0] req_pkt_i,
  output logic [num_req_p-1:0]          req_ready_o,
  output logic                          fwd_v_o,
  output logic [pkt_w_lp-1:0]           fwd_pkt_o,
  input  logic                          fwd_ready_i,
  input  logic                          ret_v_i,
  input  logic [ret_w_lp-1:0]           ret_pkt_i,
  output logic                          ret_ready_o,
  output logic [num_req_p-1:0]          resp_v_o,
  output logic [ret_w_lp-1:0]           resp_pkt_o,
  input  logic [num_req_p-1:0]          resp_ready_i,
  output logic [count_w_lp-1:0]         outstanding_o,
  output logic                          err_o
);

  localparam int pkt_rid_lsb_lp = packet_reg_id_lsb(data_width_p, x_cord_width_p, y_cord_width_p);
  localparam int ret_rid_lsb_lp = return_packet_reg_id_lsb(x_cord_width_p, y_cord_width_p);
  localparam int tag_w_lp       = (num_tags_p > 1) ? $clog2(num_tags_p) : 1;
  localparam int req_idx_w_lp   = $clog2(num_req_p);

  typedef logic [tag_w_lp-1:0]     tag_t;
  typedef logic [req_idx_w_lp-1:0] req_idx_t;

  localparam req_idx_t last_req_lp = req_idx_t'(num_req_p - 1);

  logic                  r_fwd_v;
  logic [pkt_w_lp-1:0]   r_fwd_pkt;
  req_idx_t              r_rr;
  logic                  r_err;
  req_idx_t              r_tbl_idx [num_tags_p];
  reg_id_t               r_tbl_rid [num_tags_p];

  logic                  w_load;
  logic                  w_found;
  int                    w_scan;
  req_idx_t              w_winner;
  logic                  w_grant;
  logic [pkt_w_lp-1:0]   w_sel_pkt;
  logic [pkt_w_lp-1:0]   w_fwd_pkt_next;
  logic                  w_tag_avail;
  tag_t                  w_alloc_tag;
  logic [num_tags_p-1:0] w_allocated;
  reg_id_t               w_rtag;
  tag_t                  w_rtag_idx;
  logic                  w_ret_hit;
  req_idx_t              w_ret_owner;
  logic                  w_free_v;

  bsg_manycore_hor_io_proc_arbiter_tag_pool #(
    .num_tags_p    (num_tags_p),
    .tag_width_p   (tag_w_lp),
    .count_width_p (count_w_lp)
  ) u_tag_pool (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .alloc_v_i   (w_grant),
    .free_v_i    (w_free_v),
    .free_tag_i  (w_rtag_idx),
    .avail_o     (w_tag_avail),
    .alloc_tag_o (w_alloc_tag),
    .allocated_o (w_allocated),
    .count_o     (outstanding_o)
  );

  // round-robin scan starting at the pointer
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_scan   = 0;
    for (int k = 0; k < num_req_p; k++) begin
      w_scan = int'(r_rr) + k;
      if (w_scan >= num_req_p) w_scan = w_scan - num_req_p;
      if (!w_found && req_v_i[w_scan]) begin
        w_found  = 1'b1;
        w_winner = req_idx_t'(w_scan);
      end
    end
  end

  assign w_load    = ~r_fwd_v | fwd_ready_i;
  assign w_grant   = w_found & w_tag_avail & w_load;
  assign w_sel_pkt = req_pkt_i[int'(w_winner)*pkt_w_lp +: pkt_w_lp];

  // winning packet with its reg_id replaced by the allocated tag
  always_comb begin
    w_fwd_pkt_next = w_sel_pkt;
    w_fwd_pkt_next[pkt_rid_lsb_lp +: reg_id_width_gp] = reg_id_t'(w_alloc_tag);
  end

  // one-hot handshake to the winner only
  always_comb begin
    req_ready_o = '0;
    if (w_grant) req_ready_o[w_winner] = 1'b1;
  end

  // forward output register: hold under backpressure, reload while draining
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_fwd_v   <= 1'b0;
      r_fwd_pkt <= '0;
    end else if (w_grant) begin
      r_fwd_v   <= 1'b1;
      r_fwd_pkt <= w_fwd_pkt_next;
    end else if (fwd_ready_i) begin
      r_fwd_v   <= 1'b0;
    end
  end

  // round-robin pointer moves just past the winner
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)   r_rr <= '0;
    else if (w_grant) r_rr <= (w_winner == last_req_lp) ? '0 : w_winner + req_idx_t'(1);
  end

  // tag table: owner and original reg_id, only meaningful while allocated
  always_ff @(posedge clk_i) begin
    if (w_grant) begin
      r_tbl_idx[w_alloc_tag] <= w_winner;
      r_tbl_rid[w_alloc_tag] <= w_sel_pkt[pkt_rid_lsb_lp +: reg_id_width_gp];
    end
  end

  assign w_rtag      = ret_pkt_i[ret_rid_lsb_lp +: reg_id_width_gp];
  assign w_rtag_idx  = w_rtag[tag_w_lp-1:0];
  assign w_ret_hit   = (int'(w_rtag) < num_tags_p) && w_allocated[w_rtag_idx];
  assign w_ret_owner = r_tbl_idx[w_rtag_idx];
  assign w_free_v    = ret_v_i & w_ret_hit & resp_ready_i[w_ret_owner];

  // unknown tags are swallowed so a stray response cannot wedge the router
  assign ret_ready_o = w_ret_hit ? resp_ready_i[w_ret_owner] : 1'b1;

  // response steering and reg_id restore
  always_comb begin
    resp_v_o   = '0;
    resp_pkt_o = ret_pkt_i;
    resp_pkt_o[ret_rid_lsb_lp +: reg_id_width_gp] = r_tbl_rid[w_rtag_idx];
    if (ret_v_i && w_ret_hit) resp_v_o[w_ret_owner] = 1'b1;
  end

  // sticky flag for responses carrying an unallocated tag
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)                  r_err <= 1'b0;
    else if (ret_v_i && !w_ret_hit)  r_err <= 1'b1;
  end

  assign fwd_v_o   = r_fwd_v;
  assign fwd_pkt_o = r_fwd_pkt;
  assign err_o     = r_err;

endmodule

// File: tb/tb_bsg_manycore_hor_io_proc_arbiter.sv
// Directed and randomized bench for the proc-port arbiter against a
// behavioural model of tag allocation, round-robin grant and response steering.
module tb_bsg_manycore_hor_io_proc_arbiter;

  localparam int AW = 8, DW = 8, XW = 4, YW = 3, NR = 4, NT = 4;
  // forward packet {addr, op(2), reg_id(5), payload, src_y, src_x, y, x}
  localparam int PKT_W   = AW + 2 + 5 + DW + 2*YW + 2*XW;
  localparam int PKT_RID = DW + 2*YW + 2*XW;
  // return packet {type(2), data, reg_id(5), y, x}
  localparam int RET_W   = 2 + DW + 5 + YW + XW;
  localparam int RET_RID = YW + XW;
  localparam int CW      = 3;

  logic                  clk, rst_n;
  logic [NR-1:0]         req_v;
  logic [NR*PKT_W-1:0]   req_pkt;
  logic [NR-1:0]         req_ready_o;
  logic                  fwd_v_o;
  logic [PKT_W-1:0]      fwd_pkt_o;
  logic                  fwd_ready;
  logic                  ret_v;
  logic [RET_W-1:0]      ret_pkt;
  logic                  ret_ready_o;
  logic [NR-1:0]         resp_v_o;
  logic [RET_W-1:0]      resp_pkt_o;
  logic [NR-1:0]         resp_ready;
  logic [CW-1:0]         outstanding_o;
  logic                  err_o;

  bsg_manycore_hor_io_proc_arbiter #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .num_req_p(NR), .num_tags_p(NT)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_v_i(req_v), .req_pkt_i(req_pkt), .req_ready_o(req_ready_o),
    .fwd_v_o(fwd_v_o), .fwd_pkt_o(fwd_pkt_o), .fwd_ready_i(fwd_ready),
    .ret_v_i(ret_v), .ret_pkt_i(ret_pkt), .ret_ready_o(ret_ready_o),
    .resp_v_o(resp_v_o), .resp_pkt_o(resp_pkt_o), .resp_ready_i(resp_ready),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit               m_alloc [NT];
  int               m_owner [NT];
  logic [4:0]       m_rid   [NT];
  int               m_rr;
  bit               m_fwd_v;
  logic [PKT_W-1:0] m_fwd_pkt;
  bit               m_err;
  int               m_last_tag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) m_alloc[t] = 1'b0;
    m_rr = 0; m_fwd_v = 1'b0; m_err = 1'b0; m_last_tag = 0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [4:0] rid);
    logic [PKT_W-1:0] p;
    p = PKT_W'({$urandom(), $urandom()});
    p[PKT_RID +: 5] = rid;
    req_v[i] = v;
    req_pkt[i*PKT_W +: PKT_W] = p;
  endtask

  task automatic set_ret(input bit v, input int tag);
    logic [RET_W-1:0] r;
    r = RET_W'($urandom());
    r[RET_RID +: 5] = 5'(tag);
    ret_v = v;
    ret_pkt = r;
  endtask

  // check the current cycle against the model, then advance model and clock
  task automatic cycle();
    int ftag, w, j, rtag, cnt, own;
    bit grant, hit;
    logic [PKT_W-1:0] np;
    logic [RET_W-1:0] erp;
    #1;
    if (rst_n) begin
      cnt = 0;
      for (int t = 0; t < NT; t++) if (m_alloc[t]) cnt++;
      chk("fwd_v", 64'(fwd_v_o), 64'(m_fwd_v));
      if (m_fwd_v) chk("fwd_pkt", 64'(fwd_pkt_o), 64'(m_fwd_pkt));
      chk("outstanding", 64'(outstanding_o), 64'(cnt));
      chk("err", 64'(err_o), 64'(m_err));
      ftag = -1;
      for (int t = 0; t < NT; t++) if (ftag < 0 && !m_alloc[t]) ftag = t;
      w = -1;
      for (int k = 0; k < NR; k++) begin
        j = (m_rr + k) % NR;
        if (w < 0 && req_v[j]) w = j;
      end
      grant = (w >= 0) && (ftag >= 0) && (!m_fwd_v || fwd_ready);
      chk("req_ready", 64'(req_ready_o), grant ? (64'(1) << w) : 64'(0));
      rtag = int'(ret_pkt[RET_RID +: 5]);
      hit  = (rtag < NT) && m_alloc[rtag];
      own  = hit ? m_owner[rtag] : 0;
      chk("resp_v", 64'(resp_v_o), (ret_v && hit) ? (64'(1) << own) : 64'(0));
      chk("ret_ready", 64'(ret_ready_o), hit ? 64'(resp_ready[own]) : 64'(1));
      if (ret_v && hit) begin
        erp = ret_pkt;
        erp[RET_RID +: 5] = m_rid[rtag];
        chk("resp_pkt", 64'(resp_pkt_o), 64'(erp));
      end
      if (ret_v && !hit) m_err = 1'b1;
      if (ret_v && hit && resp_ready[own]) m_alloc[rtag] = 1'b0;
      if (grant) begin
        np = req_pkt[w*PKT_W +: PKT_W];
        m_rid[ftag] = np[PKT_RID +: 5];
        np[PKT_RID +: 5] = 5'(ftag);
        m_fwd_pkt = np; m_fwd_v = 1'b1;
        m_alloc[ftag] = 1'b1; m_owner[ftag] = w;
        m_rr = (w + 1) % NR; m_last_tag = ftag;
      end else if (fwd_ready) begin
        m_fwd_v = 1'b0;
      end
    end else begin
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_v = '0; ret_v = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  logic [PKT_W-1:0] held;
  int q[$];

  initial begin
    rst_n = 1'b0; req_v = '0; req_pkt = '0; fwd_ready = 1'b0;
    ret_v = 1'b0; ret_pkt = '0; resp_ready = '0;
    model_reset();
    @(negedge clk);
    cycle(); cycle();
    rst_n = 1'b1;
    #1;
    chk("rst_fwd_v", 64'(fwd_v_o), 64'(0));
    chk("rst_outstanding", 64'(outstanding_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));

    // single request and its response
    set_req(0, 1'b1, 5'd7);
    cycle();
    req_v = '0;
    chk("t1_fwd_v", 64'(fwd_v_o), 64'(1));
    chk("t1_fwd_rid", 64'(fwd_pkt_o[PKT_RID +: 5]), 64'(0));
    chk("t1_out1", 64'(outstanding_o), 64'(1));
    fwd_ready = 1'b1; resp_ready = '1; set_ret(1'b1, 0);
    #1;
    chk("t1_resp_v", 64'(resp_v_o), 64'(4'b0001));
    chk("t1_resp_rid", 64'(resp_pkt_o[RET_RID +: 5]), 64'(7));
    cycle();
    set_ret(1'b0, 0);
    chk("t1_out0", 64'(outstanding_o), 64'(0));

    // fairness with tags recycled every cycle
    do_reset();
    fwd_ready = 1'b1; resp_ready = '1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 5'($urandom));
    for (int i = 0; i < 8; i++) begin
      if (i > 0) set_ret(1'b1, m_last_tag); else set_ret(1'b0, 0);
      #1;
      chk("t2_grant", 64'(req_ready_o), 64'(1) << (i % NR));
      cycle();
    end
    set_ret(1'b0, 0); req_v = '0;

    // tag exhaustion, then a freed tag is reused one cycle later
    do_reset();
    fwd_ready = 1'b1; resp_ready = '1;
    set_req(1, 1'b1, 5'd19);
    for (int i = 0; i < NT; i++) cycle();
    #1;
    chk("t3_exhausted", 64'(req_ready_o), 64'(0));
    cycle();
    chk("t3_out_full", 64'(outstanding_o), 64'(NT));
    set_ret(1'b1, 2);
    #1;
    chk("t3_free_same_cycle", 64'(req_ready_o), 64'(0));
    cycle();
    set_ret(1'b0, 0);
    #1;
    chk("t3_regrant", 64'(req_ready_o), 64'(4'b0010));
    cycle();
    chk("t3_tag2", 64'(fwd_pkt_o[PKT_RID +: 5]), 64'(2));
    req_v = '0;

    // forward backpressure
    do_reset();
    fwd_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 5'($urandom));
    cycle();
    fwd_ready = 1'b0;
    held = fwd_pkt_o;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_no_grant", 64'(req_ready_o), 64'(0));
      chk("t4_stable", 64'(fwd_pkt_o), 64'(held));
      cycle();
    end
    fwd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_resume", 64'(req_ready_o), 64'(1) << (i + 1));
      cycle();
    end
    req_v = '0;
    cycle();

    // out-of-order returns with a stalled accelerator
    do_reset();
    fwd_ready = 1'b1; resp_ready = '1;
    for (int i = 0; i < 3; i++) begin
      req_v = '0;
      set_req(i, 1'b1, 5'(5 + i));
      cycle();
    end
    req_v = '0;
    set_ret(1'b1, 2);
    #1;
    chk("t5_r2_v", 64'(resp_v_o), 64'(4'b0100));
    chk("t5_r2_rid", 64'(resp_pkt_o[RET_RID +: 5]), 64'(7));
    cycle();
    set_ret(1'b1, 0); resp_ready = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_stall_ready", 64'(ret_ready_o), 64'(0));
      chk("t5_stall_v", 64'(resp_v_o), 64'(4'b0001));
      cycle();
    end
    resp_ready = '1;
    #1;
    chk("t5_r0_ready", 64'(ret_ready_o), 64'(1));
    chk("t5_r0_rid", 64'(resp_pkt_o[RET_RID +: 5]), 64'(5));
    cycle();
    set_ret(1'b1, 1);
    #1;
    chk("t5_r1_v", 64'(resp_v_o), 64'(4'b0010));
    chk("t5_r1_rid", 64'(resp_pkt_o[RET_RID +: 5]), 64'(6));
    cycle();
    set_ret(1'b0, 0);
    chk("t5_out0", 64'(outstanding_o), 64'(0));

    // bad tag, then reset with requests outstanding
    set_ret(1'b1, 9);
    #1;
    chk("t6_bad_ready", 64'(ret_ready_o), 64'(1));
    chk("t6_bad_resp_v", 64'(resp_v_o), 64'(0));
    cycle();
    set_ret(1'b0, 0);
    chk("t6_err", 64'(err_o), 64'(1));
    set_req(0, 1'b1, 5'd3);
    for (int i = 0; i < 3; i++) cycle();
    req_v = '0;
    chk("t6_out3", 64'(outstanding_o), 64'(3));
    chk("t6_err_sticky", 64'(err_o), 64'(1));
    do_reset();
    #1;
    chk("t6_rst_fwd_v", 64'(fwd_v_o), 64'(0));
    chk("t6_rst_out", 64'(outstanding_o), 64'(0));
    chk("t6_rst_err", 64'(err_o), 64'(0));
    chk("t6_rst_resp_v", 64'(resp_v_o), 64'(0));
    chk("t6_rst_req_ready", 64'(req_ready_o), 64'(0));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = (i != 1500);
      for (int r = 0; r < NR; r++) set_req(r, 1'($urandom_range(0, 1)), 5'($urandom));
      fwd_ready  = ($urandom_range(0, 3) != 0);
      resp_ready = NR'($urandom());
      q.delete();
      for (int t = 0; t < NT; t++) if (m_alloc[t]) q.push_back(t);
      if (q.size() > 0 && $urandom_range(0, 2) != 0)
        set_ret(1'b1, q[$urandom_range(0, q.size() - 1)]);
      else if ($urandom_range(0, 299) == 0)
        set_ret(1'b1, int'($urandom_range(NT, 31)));
      else
        set_ret(1'b0, int'($urandom_range(0, 31)));
      cycle();
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
